// File: rtl/dso_spi_pkg.sv
// Shared definitions for the SPI arbiter slice: slave-select codes,
// the arbiter FSM state type, the default BUSY timeout, and a helper
// that tells legal slave codes from illegal ones.
package dso_spi_pkg;

   // Slave codes carried on req_ss; 5..7 select nothing and are rejected
   localparam logic [2:0] SS_TRIG = 3'd0;
   localparam logic [2:0] SS_CH1  = 3'd1;
   localparam logic [2:0] SS_CH2  = 3'd2;
   localparam logic [2:0] SS_CH3  = 3'd3;
   localparam logic [2:0] SS_EEP  = 3'd4;

   // clk cycles allowed in BUSY without SPI_done
   localparam int DEFAULT_TIMEOUT = 4096;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      LAUNCH = 3'd2,
      BUSY   = 3'd3,
      RESP   = 3'd4
   } arb_state_e;

   function automatic logic code_legal(input logic [2:0] code);
      return (code <= SS_EEP);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req               request vector, one bit per requester
//   advance, adv_idx  move the priority pointer to adv_idx+1 (mod NREQ)
//   grant_valid       at least one request is pending
//   win_idx           index of the winner (first set bit at/after pointer)
//   win_onehot        one-hot form of win_idx, zero when nothing pending
module rr_arbiter #(
   parameter int NREQ = 3,
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   input  logic [IW-1:0]   adv_idx,
   output logic            grant_valid,
   output logic [IW-1:0]   win_idx,
   output logic [NREQ-1:0] win_onehot
);

   logic [IW-1:0] ptr_r;

   // base + k folded back into 0..NREQ-1 (k < NREQ, so one subtraction suffices)
   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      else           s = s;
      return IW'(s);
   endfunction

   // Priority pointer: parks just past the requester that was last served
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {IW{1'b0}};
      end else if (advance) begin
         if (adv_idx == IW'(NREQ - 1)) ptr_r <= {IW{1'b0}};
         else                          ptr_r <= adv_idx + IW'(1'b1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Scan from the pointer upward, wrapping; first pending request wins
   always_comb begin
      grant_valid = 1'b0;
      win_idx     = {IW{1'b0}};
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_valid && req[wrap_idx(ptr_r, k)]) begin
            grant_valid = 1'b1;
            win_idx     = wrap_idx(ptr_r, k);
         end else begin
            grant_valid = grant_valid;
            win_idx     = win_idx;
         end
      end
      if (grant_valid) win_onehot = NREQ'(1'b1) << win_idx;
      else             win_onehot = {NREQ{1'b0}};
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among NREQ requesters. Round-robin grant, a
// CHECK cycle that rejects illegal slave codes, a one-cycle wrt_SPI
// launch, a BUSY wait on SPI_done with a cycle timeout, and a RESP
// cycle that pulses ack with the captured MISO word in rdata.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/req_ss/req_data      per-requester request, slave code, command word
//   gnt/ack/err              per-requester grant (level), done and error pulses
//   rdata, busy              last captured MISO word, not-idle flag
//   wrt_SPI, SPI_data        launch strobe and command word to SPI_mstr
//   SPI_done, data_in, SS_n  completion, receive word and select from SPI_mstr
//   *_ss_n                   decoded active-low slave selects
module spi_arbiter
   import dso_spi_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [3*NREQ-1:0]  req_ss,
   input  logic [16*NREQ-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    ack,
   output logic [NREQ-1:0]    err,
   output logic [15:0]        rdata,
   output logic               busy,
   output logic               wrt_SPI,
   output logic [15:0]        SPI_data,
   input  logic               SPI_done,
   input  logic [15:0]        data_in,
   input  logic               SS_n,
   output logic               trig_ss_n,
   output logic               ch1_ss_n,
   output logic               ch2_ss_n,
   output logic               ch3_ss_n,
   output logic               EEP_ss_n
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_e     state_r, state_nx_s;
   logic [IW-1:0]  idx_r;
   logic [2:0]     code_r;
   logic [15:0]    data_r;
   logic [CW-1:0]  cnt_r;
   logic           grant_valid_s, advance_s, expire_s;
   logic [IW-1:0]  win_idx_s;
   logic [NREQ-1:0] win_oh_s;
   logic [2:0]     ss_a_s   [NREQ];
   logic [15:0]    data_a_s [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign ss_a_s[i]   = req_ss[3*i +: 3];
      assign data_a_s[i] = req_data[16*i +: 16];
   end

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .advance     (advance_s),
      .adv_idx     (idx_r),
      .grant_valid (grant_valid_s),
      .win_idx     (win_idx_s),
      .win_onehot  (win_oh_s)
   );

   // Last BUSY cycle before giving up; SPI_done in this cycle still wins
   assign expire_s = (cnt_r == CW'(TIMEOUT - 1));

   // Next-state logic; the pointer moves on every exit back to IDLE
   always_comb begin
      state_nx_s = state_r;
      advance_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) state_nx_s = CHECK;
            else               state_nx_s = IDLE;
         end
         CHECK: begin
            if (code_legal(code_r)) begin
               state_nx_s = LAUNCH;
            end else begin
               state_nx_s = IDLE;
               advance_s  = 1'b1;
            end
         end
         LAUNCH: state_nx_s = BUSY;
         BUSY: begin
            if (SPI_done) begin
               state_nx_s = RESP;
            end else if (expire_s) begin
               state_nx_s = IDLE;
               advance_s  = 1'b1;
            end else begin
               state_nx_s = BUSY;
            end
         end
         RESP: begin
            state_nx_s = IDLE;
            advance_s  = 1'b1;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register plus all registered outputs and transaction latches
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         idx_r    <= {IW{1'b0}};
         code_r   <= 3'd0;
         data_r   <= 16'd0;
         cnt_r    <= {CW{1'b0}};
         gnt      <= {NREQ{1'b0}};
         ack      <= {NREQ{1'b0}};
         err      <= {NREQ{1'b0}};
         rdata    <= 16'd0;
         busy     <= 1'b0;
         wrt_SPI  <= 1'b0;
         SPI_data <= 16'd0;
      end else begin
         state_r <= state_nx_s;
         busy    <= (state_nx_s != IDLE);
         wrt_SPI <= (state_r == CHECK) && (state_nx_s == LAUNCH);
         ack     <= {NREQ{1'b0}};
         err     <= {NREQ{1'b0}};
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  idx_r  <= win_idx_s;
                  code_r <= ss_a_s[win_idx_s];
                  data_r <= data_a_s[win_idx_s];
                  gnt    <= win_oh_s;
               end else begin
                  gnt <= {NREQ{1'b0}};
               end
            end
            CHECK: begin
               if (state_nx_s == LAUNCH) begin
                  SPI_data <= data_r;
               end else begin
                  err <= gnt;
                  gnt <= {NREQ{1'b0}};
               end
            end
            LAUNCH: cnt_r <= {CW{1'b0}};
            BUSY: begin
               if (SPI_done) begin
                  rdata <= data_in;
                  ack   <= gnt;
               end else if (expire_s) begin
                  err <= gnt;
                  gnt <= {NREQ{1'b0}};
               end else begin
                  cnt_r <= cnt_r + CW'(1'b1);
               end
            end
            RESP:    gnt <= {NREQ{1'b0}};
            default: gnt <= {NREQ{1'b0}};
         endcase
      end
   end

   // Select decode: only the owned slave follows SS_n, LAUNCH through RESP
   always_comb begin
      trig_ss_n = 1'b1;
      ch1_ss_n  = 1'b1;
      ch2_ss_n  = 1'b1;
      ch3_ss_n  = 1'b1;
      EEP_ss_n  = 1'b1;
      if ((state_r == LAUNCH) || (state_r == BUSY) || (state_r == RESP)) begin
         case (code_r)
            SS_TRIG: trig_ss_n = SS_n;
            SS_CH1:  ch1_ss_n  = SS_n;
            SS_CH2:  ch2_ss_n  = SS_n;
            SS_CH3:  ch3_ss_n  = SS_n;
            SS_EEP:  EEP_ss_n  = SS_n;
            default: trig_ss_n = 1'b1;
         endcase
      end else begin
         trig_ss_n = 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter (NREQ=3, TIMEOUT=16). A small
// transaction-level model (round-robin pointer, expected winner, latency
// in cycles, expected select pattern, last read word) predicts every value.
module tb_spi_arbiter;

   localparam int N   = 3;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [3*N-1:0]  req_ss;
   logic [16*N-1:0] req_data;
   logic [N-1:0]  gnt, ack, err;
   logic [15:0]   rdata, SPI_data, data_in;
   logic          busy, wrt_SPI, SPI_done, SS_n;
   logic          trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n;
   logic [4:0]    sel;

   int total = 0;
   int bad   = 0;
   int mptr  = 0;
   logic [15:0] rdata_m = 16'd0;

   assign sel = {trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n};

   spi_arbiter #(.NREQ(N), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_ss(req_ss), .req_data(req_data),
      .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
      .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .SPI_done(SPI_done),
      .data_in(data_in), .SS_n(SS_n),
      .trig_ss_n(trig_ss_n), .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n),
      .ch3_ss_n(ch3_ss_n), .EEP_ss_n(EEP_ss_n)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // First pending requester at or after ptr, wrapping; -1 if none
   function automatic int model_pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (((r >> ((ptr + k) % N)) & 3'd1) != 3'd0) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Select pattern {trig,ch1,ch2,ch3,eep} while a slave with this code is active
   function automatic logic [4:0] exp_sel(input logic [2:0] code, input logic ss);
      logic [4:0] v;
      v = 5'h1f;
      if (code <= 3'd4 && !ss) v = v & ~(5'h10 >> code);
      return v;
   endfunction

   task automatic set_slot(input int i, input logic [2:0] code, input logic [15:0] data);
      logic [3*N-1:0]  ms;
      logic [16*N-1:0] md;
      ms = {3*N{1'b0}} | 3'b111;
      md = {16*N{1'b0}} | 16'hffff;
      req_ss   = (req_ss & ~(ms << (3*i))) | ((({3*N{1'b0}} | code)) << (3*i));
      req_data = (req_data & ~(md << (16*i))) | ((({16*N{1'b0}} | data)) << (16*i));
   endtask

   // One complete transaction, starting with the DUT idle and req already set.
   // d = BUSY cycles before SPI_done (d >= TMO means never -> timeout).
   task automatic do_txn(input int d, input logic [15:0] miso, input bit keep, input bit drop_early);
      int w;
      logic [2:0] code;
      logic [15:0] data;
      logic [N-1:0] oh;
      logic [4:0] es;
      w = model_pick(req, mptr);
      total++;
      if (w < 0) begin
         bad++;
         $display("FAIL txn_setup: actual=no pending request required=one");
         return;
      end
      code = 3'(req_ss >> (3*w));
      data = 16'(req_data >> (16*w));
      oh   = N'(3'd1 << w);
      es   = exp_sel(code, 1'b0);
      SS_n = 1'b0;
      tick();  // CHECK
      total++; if (gnt !== oh) begin bad++; $display("FAIL gnt_grant: actual=%b required=%b", gnt, oh); end
      total++; if (busy !== 1'b1 || wrt_SPI !== 1'b0) begin bad++; $display("FAIL check_cycle: actual busy=%b wrt=%b required busy=1 wrt=0", busy, wrt_SPI); end
      total++; if (sel !== 5'h1f) begin bad++; $display("FAIL sel_check: actual=%b required=11111", sel); end
      if (drop_early) req = req & ~oh;
      tick();
      if (code > 3'd4) begin
         total++; if (err !== oh || gnt !== {N{1'b0}}) begin bad++; $display("FAIL illegal_err: actual err=%b gnt=%b required err=%b gnt=000", err, gnt, oh); end
         total++; if (wrt_SPI !== 1'b0 || busy !== 1'b0 || sel !== 5'h1f) begin bad++; $display("FAIL illegal_idle: actual wrt=%b busy=%b sel=%b required 0 0 11111", wrt_SPI, busy, sel); end
         if (!keep) req = req & ~oh;
         SS_n = 1'b1;
         mptr = (w + 1) % N;
         return;
      end
      total++; if (wrt_SPI !== 1'b1 || SPI_data !== data) begin bad++; $display("FAIL launch: actual wrt=%b data=%h required wrt=1 data=%h", wrt_SPI, SPI_data, data); end
      total++; if (sel !== es) begin bad++; $display("FAIL sel_launch: actual=%b required=%b", sel, es); end
      tick();  // BUSY, count 0
      total++; if (wrt_SPI !== 1'b0 || SPI_data !== data) begin bad++; $display("FAIL busy_entry: actual wrt=%b data=%h required wrt=0 data=%h", wrt_SPI, SPI_data, data); end
      if (d >= TMO) begin
         for (int i = 1; i < TMO; i++) begin
            tick();
            total++; if (err !== {N{1'b0}} || gnt !== oh || sel !== es) begin bad++; $display("FAIL busy_wait: cycle=%0d actual err=%b gnt=%b sel=%b required err=000 gnt=%b sel=%b", i, err, gnt, sel, oh, es); end
         end
         tick();
         total++; if (err !== oh || gnt !== {N{1'b0}} || busy !== 1'b0) begin bad++; $display("FAIL timeout: actual err=%b gnt=%b busy=%b required err=%b gnt=000 busy=0", err, gnt, busy, oh); end
         total++; if (ack !== {N{1'b0}} || rdata !== rdata_m || sel !== 5'h1f) begin bad++; $display("FAIL timeout_side: actual ack=%b rdata=%h sel=%b required ack=000 rdata=%h sel=11111", ack, rdata, sel, rdata_m); end
         SS_n = 1'b1;
         if (!keep) req = req & ~oh;
         mptr = (w + 1) % N;
         return;
      end
      for (int i = 0; i < d; i++) begin
         tick();
         total++; if (ack !== {N{1'b0}} || gnt !== oh || sel !== es) begin bad++; $display("FAIL busy_wait: cycle=%0d actual ack=%b gnt=%b sel=%b required ack=000 gnt=%b sel=%b", i, ack, gnt, sel, oh, es); end
      end
      SPI_done = 1'b1;
      data_in  = miso;
      tick();  // RESP
      SPI_done = 1'b0;
      data_in  = 16'($urandom);
      rdata_m  = miso;
      total++; if (ack !== oh || err !== {N{1'b0}}) begin bad++; $display("FAIL ack: actual ack=%b err=%b required ack=%b err=000", ack, err, oh); end
      total++; if (rdata !== miso || gnt !== oh || sel !== es) begin bad++; $display("FAIL resp: actual rdata=%h gnt=%b sel=%b required rdata=%h gnt=%b sel=%b", rdata, gnt, sel, miso, oh, es); end
      SS_n = 1'b1;
      if (!keep) req = req & ~oh;
      tick();  // back in IDLE
      total++; if (ack !== {N{1'b0}} || gnt !== {N{1'b0}} || busy !== 1'b0 || sel !== 5'h1f) begin bad++; $display("FAIL post_resp: actual ack=%b gnt=%b busy=%b sel=%b required 000 000 0 11111", ack, gnt, busy, sel); end
      total++; if (rdata !== rdata_m) begin bad++; $display("FAIL rdata_hold: actual=%h required=%h", rdata, rdata_m); end
      mptr = (w + 1) % N;
   endtask

   task automatic check_idle(input string tag);
      total++;
      if (gnt !== {N{1'b0}} || ack !== {N{1'b0}} || err !== {N{1'b0}} || busy !== 1'b0 || wrt_SPI !== 1'b0 || sel !== 5'h1f) begin
         bad++;
         $display("FAIL %s: actual gnt=%b ack=%b err=%b busy=%b wrt=%b sel=%b required all idle", tag, gnt, ack, err, busy, wrt_SPI, sel);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = {N{1'b0}}; req_ss = {3*N{1'b0}}; req_data = {16*N{1'b0}};
      SPI_done = 1'b0; data_in = 16'd0; SS_n = 1'b0;
      tick(); tick();
      check_idle("reset_ctrl");
      total++; if (rdata !== 16'd0 || SPI_data !== 16'd0) begin bad++; $display("FAIL reset_data: actual rdata=%h spi=%h required 0 0", rdata, SPI_data); end
      rst = 1'b0; SS_n = 1'b1; mptr = 0; rdata_m = 16'd0;
      tick();
   endtask

   task automatic test_single_write();
      set_slot(0, 3'd0, 16'h1380);
      req = 3'b001;
      do_txn(3, 16'($urandom), 1'b0, 1'b0);
   endtask

   task automatic test_eeprom_read();
      set_slot(1, 3'd4, 16'($urandom));
      req = 3'b010;
      do_txn(5, 16'h00A5, 1'b0, 1'b0);
   endtask

   task automatic test_contention();
      for (int i = 0; i < N; i++) set_slot(i, 3'(i + 1), 16'($urandom));
      req = 3'b111; rst = 1'b1;
      tick();
      rst = 1'b0; mptr = 0;
      for (int t = 0; t < 6; t++) do_txn(int'($urandom_range(0, 4)), 16'($urandom), 1'b1, 1'b0);
      req = {N{1'b0}};
   endtask

   task automatic test_illegal();
      set_slot(2, 3'd6, 16'hBEEF);
      req = 3'b100;
      do_txn(0, 16'd0, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) set_slot(i, 3'd2, 16'($urandom));
      req = 3'b111;
      do_txn(1, 16'($urandom), 1'b0, 1'b0);
      req = {N{1'b0}};
   endtask

   task automatic test_timeout();
      set_slot(0, 3'd1, 16'h5A5A);
      req = 3'b001;
      do_txn(TMO + 5, 16'd0, 1'b0, 1'b0);
      set_slot(1, 3'd3, 16'h0F0F);
      req = 3'b010;
      do_txn(2, 16'($urandom), 1'b0, 1'b0);
   endtask

   task automatic test_reset_busy();
      set_slot(1, 3'd2, 16'h7777);
      req = 3'b010;
      tick(); tick(); tick();  // CHECK, LAUNCH, BUSY
      SS_n = 1'b0;
      rst = 1'b1; req = {N{1'b0}};
      tick();
      rst = 1'b0;
      mptr = 0; rdata_m = 16'd0;
      check_idle("reset_busy");
      total++; if (rdata !== 16'd0 || SPI_data !== 16'd0) begin bad++; $display("FAIL reset_busy_data: actual rdata=%h spi=%h required 0 0", rdata, SPI_data); end
      SPI_done = 1'b1;
      tick();
      SPI_done = 1'b0; SS_n = 1'b1;
      check_idle("reset_no_ack");
      set_slot(1, 3'd3, 16'($urandom));
      set_slot(2, 3'd0, 16'($urandom));
      req = 3'b110;
      do_txn(TMO - 1, 16'($urandom), 1'b0, 1'b0);
      req = {N{1'b0}};
   endtask

   task automatic test_done_ignored();
      req = {N{1'b0}};
      SPI_done = 1'b1; data_in = 16'hDEAD;
      tick(); tick(); tick();
      SPI_done = 1'b0;
      check_idle("done_in_idle");
      total++; if (rdata !== rdata_m) begin bad++; $display("FAIL done_idle_rdata: actual=%h required=%h", rdata, rdata_m); end
   endtask

   task automatic test_random();
      logic [2:0] c;
      for (int it = 0; it < 24; it++) begin
         for (int i = 0; i < N; i++) begin
            c = ($urandom_range(0, 5) == 0) ? 3'(5 + $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            set_slot(i, c, 16'($urandom));
         end
         req = req | 3'($urandom_range(1, 7));
         do_txn(int'($urandom_range(0, TMO + 1)), 16'($urandom), 1'b0, $urandom_range(0, 3) == 0);
      end
      req = {N{1'b0}};
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_eeprom_read();
      test_contention();
      test_illegal();
      test_timeout();
      test_reset_busy();
      test_done_ignored();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single SPI master among NREQ requesters, e.g. the host-command path in dig_core, the boot-time EEPROM calibration loader and the trigger-level refresher.
- Arbitration is round-robin. Each transaction targets one of the five slaves.
- The block sequences the master's wrt/done handshake and returns the read data to the requester.
- It decodes the master's single SS_n into trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n and EEP_ss_n.
- It sits between the requesters and SPI_mstr in DSO_dig, replacing the ad-hoc select decode.

Parameters:
- NREQ, 3, number of requesters (1..8).
- TIMEOUT, 4096, clk cycles allowed in BUSY without SPI_done before the transaction is aborted.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; level, held until ack or err.
- req_ss  in  3*NREQ  slave code per requester, slice i = [3i+2:3i].
- req_data  in  16*NREQ  SPI command word per requester.
- gnt  out  NREQ  one-hot; high for the whole owned transaction.
- ack  out  NREQ  one-cycle pulse on completion.
- err  out  NREQ  one-cycle pulse on bad slave code or timeout.
- rdata  out  16  captured MISO word; valid from the ack cycle until the next capture.
- busy  out  1  high in any state other than IDLE.
- wrt_SPI  out  1  one-cycle start pulse to SPI_mstr.
- SPI_data  out  16  word to SPI_mstr; stable from LAUNCH through BUSY.
- SPI_done  in  1  completion pulse from SPI_mstr.
- data_in  in  16  SPI_mstr receive word.
- SS_n  in  1  SPI_mstr slave select.
- trig_ss_n, ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n  out  1 each  decoded active-low selects.

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - state = IDLE.
  - gnt, ack, err, wrt_SPI and busy = 0.
  - rdata = 0 and SPI_data = 0.
  - All five selects = 1.
  - Round-robin pointer = 0, so requester 0 has highest priority on the first arbitration.
  - Reset mid-transaction aborts immediately. No ack or err is issued.
- Slave codes: 0 = trig, 1 = ch1, 2 = ch2, 3 = ch3, 4 = EEP. Codes 5-7 are illegal.
- State IDLE:
  - If any req bit is set, pick the first set bit at or after the pointer, wrapping modulo NREQ.
  - Latch the winner index, its code and its data. Assert gnt[idx] and go to CHECK.
- State CHECK (1 cycle):
  - Illegal code: pulse err[idx], drop gnt, advance the pointer to idx+1 and go to IDLE. No wrt_SPI is issued and no select toggles.
  - Legal code: go to LAUNCH.
- State LAUNCH (1 cycle): wrt_SPI = 1, SPI_data = latched word, then go to BUSY.
- Latency: req sampled at edge 0 gives gnt at edge 1 and wrt_SPI high during cycle 2.
- State BUSY:
  - Count cycles. When SPI_done = 1, capture data_in into rdata and go to RESP.
  - If the count reaches TIMEOUT with no SPI_done, pulse err[idx], leave rdata unchanged, go to IDLE and advance the pointer.
  - SPI_done in the same cycle the count expires: done wins.
- State RESP (1 cycle): ack[idx] = 1, gnt drops next cycle, pointer = idx+1 mod NREQ, go to IDLE.
- Back-to-back: a held req may be re-granted no earlier than the IDLE cycle that follows RESP.
- Select decode (combinational from registered code and state):
  - Only the selected output follows SS_n, and only from LAUNCH through RESP.
  - All other selects are 1. In IDLE and CHECK all selects are 1.
  - An illegal code never drives any select low.
- req dropped mid-transaction: the transaction completes and ack still pulses.
- SPI_done in IDLE, CHECK or LAUNCH: ignored.

Decomposition:
- Package dso_spi_pkg holds:
  - slave-code constants SS_TRIG, SS_CH1, SS_CH2, SS_CH3, SS_EEP;
  - the state enum (IDLE, CHECK, LAUNCH, BUSY, RESP);
  - the default TIMEOUT.
- Sub-module rr_arbiter holds the pointer, the rotate-priority-select logic and one-hot/index output, with an advance strobe.
- The FSM, timeout counter and select decode live in spi_arbiter.

Test Plan:
- Single write, req0 with code 0 and data 16'h1380: wrt_SPI 2 cycles after req, only trig_ss_n follows SS_n, model done → ack[0] 1 cycle after done, rdata = data_in, selects all 1 afterwards.
- EEPROM read, req1 with code 4 and data_in driven 16'h00A5 at done: rdata = 16'h00A5 at ack[1], EEP_ss_n is the only select toggling.
- Contention, req0/1/2 all held continuously from reset: grant order 0,1,2,0,1,2; gnt never more than one-hot.
- Illegal code 6 on req2: err[2] 1 cycle after gnt, no wrt_SPI, all selects stay 1, pointer advances to 0.
- Timeout with TIMEOUT=16 and SPI_done never asserted: err pulses 16 cycles after entering BUSY, busy falls, the next request is served normally.
- Reset asserted in BUSY: next cycle everything is idle, selects high and no ack; done arriving at the same edge as timeout expiry gives ack, not err.
